// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO result registers.
// Multiply is shift-add on magnitudes, divide is restoring shift-subtract on
// magnitudes; signs are re-applied in a single FIX cycle before HI/LO update.
module mult_div_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's complement negation helpers.
  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] x);
    f_neg_w = ~x + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] x);
    f_neg_2w = ~x + ONE_2W;
  endfunction

  // Control / datapath state
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_res;   // product or quotient must be negated
  logic               r_neg_rem;   // remainder must be negated (dividend sign)
  logic [WIDTH-1:0]   r_opb;       // |b|: multiplicand or divisor
  logic [2*WIDTH-1:0] r_acc;       // MULT {partial, multiplier}; DIV {remainder, quotient}
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Combinational nets
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_commit;
  logic               w_dz_hit;
  logic               w_signed_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_zero_req;
  logic               w_cnt_last;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Operand decode: magnitudes and sign flags of the incoming operands.
  always_comb begin
    w_signed_op    = ~i_op[0];
    w_a_neg        = w_signed_op & i_a[WIDTH-1];
    w_b_neg        = w_signed_op & i_b[WIDTH-1];
    w_a_mag        = w_a_neg ? f_neg_w(i_a) : i_a;
    w_b_mag        = w_b_neg ? f_neg_w(i_b) : i_b;
    w_div_zero_req = i_op[1] & (i_b == ZERO_W);
    w_cnt_last     = (r_cnt == CNT_LAST);
  end

  // One clock worth of iteration: BITS_PER_CYCLE shift-add or shift-subtract steps.
  always_comb begin
    w_acc_step = r_acc;
    w_rem_sh   = {(WIDTH+1){1'b0}};
    w_diff     = {(WIDTH+1){1'b0}};
    w_sum      = {(WIDTH+1){1'b0}};
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (r_is_div) begin
        // Remainder shifted left by one needs WIDTH+1 bits before the trial subtract.
        w_rem_sh = w_acc_step[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, r_opb};
        if (!w_diff[WIDTH]) begin
          w_acc_step = {w_diff[WIDTH-1:0], w_acc_step[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_step = {w_rem_sh[WIDTH-1:0], w_acc_step[WIDTH-2:0], 1'b0};
        end
      end else begin
        w_sum      = {1'b0, w_acc_step[2*WIDTH-1:WIDTH]} +
                     (w_acc_step[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_acc_step = {w_sum, w_acc_step[WIDTH-1:1]};
      end
    end
  end

  // Sign correction of the finished magnitudes into HI/LO form.
  always_comb begin
    w_prod = r_neg_res ? f_neg_2w(r_acc) : r_acc;
    w_quot = r_neg_res ? f_neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_rem  = r_neg_rem ? f_neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // Next-state and control strobes for the IDLE/RUN/FIX sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    w_dz_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_div_zero_req) begin
            w_dz_hit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_cancel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_cnt_last) begin
            w_state_nxt = ST_FIX;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_FIX: begin
        if (i_cancel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt     <= {CW{1'b0}};
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opb     <= ZERO_W;
      r_acc     <= {(2*WIDTH){1'b0}};
    end else if (w_load) begin
      // Both ops iterate over |a| in the low half with |b| as the other operand.
      r_cnt     <= {CW{1'b0}};
      r_is_div  <= i_op[1];
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_opb     <= w_b_mag;
      r_acc     <= {ZERO_W, w_a_mag};
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_ONE;
      r_acc <= w_acc_step;
    end
  end

  // Registered handshake outputs and HI/LO result registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= ZERO_W;
      r_lo       <= ZERO_W;
    end else begin
      r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FIX);
      r_done     <= w_commit | w_dz_hit;
      r_div_zero <= w_dz_hit;
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: two instances (1 and 4 bits per cycle)
// share stimulus; a transaction-level model predicts every output each cycle.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cancel;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  logic [1:0]  d_busy;
  logic [1:0]  d_done;
  logic [1:0]  d_dz;
  logic [31:0] d_hi [2];
  logic [31:0] d_lo [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_cancel(cancel), .o_busy(d_busy[0]), .o_done(d_done[0]), .o_div_zero(d_dz[0]),
    .o_hi(d_hi[0]), .o_lo(d_lo[0])
  );

  mult_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_cancel(cancel), .o_busy(d_busy[1]), .o_done(d_done[1]), .o_div_zero(d_dz[1]),
    .o_hi(d_hi[1]), .o_lo(d_lo[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {hi, lo} of an op with nonzero divisor.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: ref_result = sx * sy;
      2'b01: ref_result = ux * uy;
      2'b10: begin
        q = sx / sy;
        r = sx % sy;
        ref_result = {r[31:0], q[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        ref_result = {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int n_iter(input int i);
    n_iter = (i == 0) ? 32 : 8;
  endfunction

  // Model: m_rem = cycles left until the result lands (0 = idle).
  int          m_rem [2];
  logic        m_done [2];
  logic        m_dz [2];
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] m_phi [2];
  logic [31:0] m_plo [2];

  // Transaction-level model advanced on each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i] <= 0; m_done[i] <= 1'b0; m_dz[i] <= 1'b0;
        m_hi[i] <= 32'h0; m_lo[i] <= 32'h0; m_phi[i] <= 32'h0; m_plo[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        m_dz[i]   <= 1'b0;
        if (m_rem[i] == 0) begin
          if (start) begin
            if (op[1] && b == 32'h0) begin
              m_done[i] <= 1'b1;
              m_dz[i]   <= 1'b1;
            end else begin
              {m_phi[i], m_plo[i]} <= ref_result(op, a, b);
              m_rem[i] <= n_iter(i) + 1;
            end
          end
        end else if (cancel) begin
          m_rem[i] <= 0;
        end else if (m_rem[i] == 1) begin
          m_rem[i]  <= 0;
          m_hi[i]   <= m_phi[i];
          m_lo[i]   <= m_plo[i];
          m_done[i] <= 1'b1;
        end else begin
          m_rem[i] <= m_rem[i] - 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cycle_dut%0d{busy,done,dz,hi,lo}", i),
            {d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]},
            {m_rem[i] != 0, m_done[i], m_dz[i], m_hi[i], m_lo[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // lat counts edges from the edge before start was driven; busy_cnt counts busy samples.
  task automatic wait_done(input int i, input int budget, output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (d_done[i] !== 1'b1 && lat < budget) begin
      if (d_busy[i] === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    if (d_done[i] !== 1'b1) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (d_busy !== 2'b00 && t < 100) begin
      tick();
      t++;
    end
    chk("idle_timeout", d_busy, 2'b00);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: pick = 32'h0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h1;
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, bc, seen;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", {d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]}, 67'h0);
    end

    // MULT -3 * 5
    launch(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(0, 60, lat, bc);
    chk("mult_latency", lat, 34);
    chk("mult_busy_cycles", bc, 33);
    chk("mult_busy_in_done", d_busy[0], 1'b0);
    chk("mult_hi", d_hi[0], 32'hFFFF_FFFF);
    chk("mult_lo", d_lo[0], 32'hFFFF_FFF1);
    wait_idle();

    // DIVU 100 / 7
    launch(2'b11, 32'd100, 32'd7);
    wait_done(0, 60, lat, bc);
    chk("divu_lo", d_lo[0], 32'd14);
    chk("divu_hi", d_hi[0], 32'd2);
    wait_idle();

    // DIV -7 / 2
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 60, lat, bc);
    chk("div_neg_lo", d_lo[0], 32'hFFFF_FFFD);
    chk("div_neg_hi", d_hi[0], 32'hFFFF_FFFF);
    wait_idle();

    // DIV MIN / -1
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 60, lat, bc);
    chk("div_min_lo", d_lo[0], 32'h8000_0000);
    chk("div_min_hi", d_hi[0], 32'h0);
    chk("div_min_dz", d_dz[0], 1'b0);
    wait_idle();

    // Preload hi=5 lo=6, then divide by zero
    launch(2'b11, 32'd47, 32'd7);
    wait_done(0, 60, lat, bc);
    chk("preload_hi", d_hi[0], 32'd5);
    chk("preload_lo", d_lo[0], 32'd6);
    wait_idle();
    launch(2'b10, 32'd123, 32'h0);
    chk("dz_done", d_done[0], 1'b1);
    chk("dz_flag", d_dz[0], 1'b1);
    chk("dz_busy", d_busy[0], 1'b0);
    chk("dz_hi", d_hi[0], 32'd5);
    chk("dz_lo", d_lo[0], 32'd6);
    tick();
    chk("dz_busy_after", d_busy, 2'b00);
    chk("dz_pulse_width", d_done[0], 1'b0);

    // Back-to-back: second start in the done cycle
    wait_idle();
    launch(2'b01, 32'h1234_5678, 32'd9);
    wait_done(0, 60, lat, bc);
    chk("b2b_first_lo", d_lo[0], 32'hA3D7_0A38);
    chk("b2b_first_hi", d_hi[0], 32'h0);
    launch(2'b11, 32'd1000, 32'd3);
    wait_done(0, 60, lat, bc);
    chk("b2b_second_latency", lat, 34);
    chk("b2b_second_lo", d_lo[0], 32'd333);
    chk("b2b_second_hi", d_hi[0], 32'd1);
    wait_idle();

    // Start pulse mid-RUN is ignored
    launch(2'b01, 32'd6, 32'd7);
    repeat (5) tick();
    launch(2'b01, 32'd2, 32'd2);
    wait_done(0, 60, lat, bc);
    chk("ignored_start_latency", lat, 28);
    chk("ignored_start_lo", d_lo[0], 32'd42);
    chk("ignored_start_hi", d_hi[0], 32'd0);
    wait_idle();

    // Cancel at RUN cycle 10
    launch(2'b01, 32'd123, 32'd456);
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", d_busy[0], 1'b0);
    chk("cancel_hi", d_hi[0], 32'd0);
    chk("cancel_lo", d_lo[0], 32'd42);
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (d_done[0] === 1'b1) seen++;
      tick();
    end
    chk("cancel_no_done", seen, 0);
    chk("cancel_lo_held", d_lo[0], 32'd42);
    wait_idle();

    // Async reset mid-RUN
    launch(2'b00, 32'd77, 32'hFFFF_FFF7);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_midrun", {d_busy[i], d_done[i], d_dz[i], d_hi[i], d_lo[i]}, 67'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_release", {d_busy, d_done, d_dz, d_hi[0], d_lo[0], d_hi[1], d_lo[1]}, 134'h0);

    // Four bits per cycle: MULTU all-ones squared
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, 30, lat, bc);
    chk("bpc4_latency", lat, 10);
    chk("bpc4_busy_cycles", bc, 9);
    chk("bpc4_hi", d_hi[1], 32'hFFFF_FFFE);
    chk("bpc4_lo", d_lo[1], 32'h0000_0001);
    wait_idle();

    // Randomized traffic: starts, cancels, corner operands
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom % 4) == 0;
      cancel = ($urandom % 50) == 0;
      op     = 2'($urandom);
      a      = pick();
      b      = pick();
      tick();
    end
    start = 1'b0;
    cancel = 1'b0;
    wait_idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
